// File: rtl/pll_drp_cfg_ctrl_if.sv
// Host table/control, DRP and PLL-control signals of the PLL DRP reconfiguration sequencer.
// slave = sequencer side, master = host / DRP / PLL environment side.
interface pll_drp_cfg_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int IDX_W = $clog2(DEPTH);

    logic             ent_wr;
    logic [IDX_W-1:0] ent_idx;
    logic [6:0]       ent_addr;
    logic [15:0]      ent_mask;
    logic [15:0]      ent_data;
    logic [IDX_W:0]   ent_num;
    logic             cfg_start;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;
    logic [1:0]       err_code;
    logic [6:0]       drp_daddr;
    logic             drp_den;
    logic             drp_dwe;
    logic [15:0]      drp_di;
    logic [15:0]      drp_do;
    logic             drp_drdy;
    logic             pll_rst;
    logic             pll_locked;

    modport slave (
        input  ent_wr, ent_idx, ent_addr, ent_mask, ent_data, ent_num, cfg_start,
        input  drp_do, drp_drdy, pll_locked,
        output cfg_busy, cfg_done, cfg_err, err_code,
        output drp_daddr, drp_den, drp_dwe, drp_di, pll_rst
    );

    modport master (
        output ent_wr, ent_idx, ent_addr, ent_mask, ent_data, ent_num, cfg_start,
        output drp_do, drp_drdy, pll_locked,
        input  cfg_busy, cfg_done, cfg_err, err_code,
        input  drp_daddr, drp_den, drp_dwe, drp_di, pll_rst
    );
endinterface

// File: rtl/pll_drp_cfg_ctrl.sv
// PLL DRP reconfiguration sequencer: hold PLL in reset, read-modify-write each table entry, release, wait for lock.
// Define PLL_DRP_READBACK_EN to verify every write with a DRP readback (error code 3 on mismatch).
module pll_drp_cfg_ctrl #(
    parameter int DEPTH    = 8,
    parameter int RST_HOLD = 16,
    parameter int DRDY_TMO = 255,
    parameter int LOCK_TMO = 65535
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst,
    pll_drp_cfg_ctrl_if.slave if_cfg
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int NUM_W   = IDX_W + 1;
    localparam int MAX_AB  = (LOCK_TMO > DRDY_TMO) ? LOCK_TMO : DRDY_TMO;
    localparam int CNT_MAX = (MAX_AB > RST_HOLD) ? MAX_AB : RST_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TMO - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TMO - 1);
    localparam logic [CNT_W-1:0] GUARD     = CNT_W'(2);
    localparam logic [NUM_W-1:0] NUM_MAX   = NUM_W'(DEPTH);

    localparam logic [1:0] ERR_DRDY = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;
`ifdef PLL_DRP_READBACK_EN
    localparam logic [1:0] ERR_VERIFY = 2'd3;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_RST_HOLD, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT,
`ifdef PLL_DRP_READBACK_EN
        S_VF_REQ, S_VF_WAIT,
`endif
        S_LOCK_WAIT, S_FIN
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [NUM_W-1:0] r_num;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_tbl_addr [DEPTH];
    logic [15:0]      r_tbl_mask [DEPTH];
    logic [15:0]      r_tbl_data [DEPTH];
    logic             r_lock_meta;
    logic             r_lock_sync;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [6:0]       r_daddr;
    logic             r_den;
    logic             r_dwe;
    logic [15:0]      r_di;
    logic             r_pll_rst;

    logic             w_last;
    logic             w_lock_ok;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [NUM_W-1:0] w_num_clamped;
    logic [15:0]      w_rmw_di;

    assign w_last        = ({1'b0, r_ptr} == (r_num - NUM_W'(1)));
    assign w_lock_ok     = r_lock_sync && (r_cnt >= GUARD);
    assign w_ptr_nxt     = r_ptr + IDX_W'(1);
    assign w_num_clamped = (if_cfg.ent_num > NUM_MAX) ? NUM_MAX : if_cfg.ent_num;
    assign w_rmw_di      = (if_cfg.drp_do & r_tbl_mask[r_ptr]) | r_tbl_data[r_ptr];

    // NOTE: the table is a register file with a defined all-zero reset value, so every entry is reset here.
    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl_addr[i] <= '0;
                r_tbl_mask[i] <= '0;
                r_tbl_data[i] <= '0;
            end
        end else if (if_cfg.ent_wr && !r_busy) begin
            r_tbl_addr[if_cfg.ent_idx] <= if_cfg.ent_addr;
            r_tbl_mask[if_cfg.ent_idx] <= if_cfg.ent_mask;
            r_tbl_data[if_cfg.ent_idx] <= if_cfg.ent_data;
        end
    end

    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= if_cfg.pll_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every branch reads pre-edge register values.
    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_num      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= '0;
            r_daddr    <= '0;
            r_den      <= 1'b0;
            r_dwe      <= 1'b0;
            r_di       <= '0;
            r_pll_rst  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_den  <= 1'b0;
            r_dwe  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (if_cfg.cfg_start) begin
                        r_num      <= w_num_clamped;
                        r_ptr      <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_pll_rst  <= 1'b1;
                        r_err_code <= '0;
                        r_state    <= S_RST_HOLD;
                    end
                end
                S_RST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt <= '0;
                        if (r_num != '0) begin
                            r_daddr <= r_tbl_addr[r_ptr];
                            r_den   <= 1'b1;
                            r_state <= S_RD_REQ;
                        end else begin
                            r_pll_rst <= 1'b0;
                            r_state   <= S_LOCK_WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef PLL_DRP_READBACK_EN
                S_RD_REQ, S_WR_REQ, S_VF_REQ: begin
`else
                S_RD_REQ, S_WR_REQ: begin
`endif
                    // Counter restarted at DEN; it equals cycles-since-DEN inside the wait state.
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_state <= (r_state == S_RD_REQ) ? S_RD_WAIT :
`ifdef PLL_DRP_READBACK_EN
                               (r_state == S_VF_REQ) ? S_VF_WAIT :
`endif
                               S_WR_WAIT;
                end
                S_RD_WAIT: begin
                    if (if_cfg.drp_drdy) begin
                        r_di    <= w_rmw_di;
                        r_den   <= 1'b1;
                        r_dwe   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_WR_REQ;
                    end else if (r_cnt == DRDY_LAST) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_DRDY;
                        r_busy     <= 1'b0;
                        r_pll_rst  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WR_WAIT: begin
                    if (if_cfg.drp_drdy) begin
                        r_cnt <= '0;
`ifdef PLL_DRP_READBACK_EN
                        r_den   <= 1'b1;
                        r_state <= S_VF_REQ;
`else
                        if (w_last) begin
                            r_pll_rst <= 1'b0;
                            r_state   <= S_LOCK_WAIT;
                        end else begin
                            r_ptr   <= w_ptr_nxt;
                            r_daddr <= r_tbl_addr[w_ptr_nxt];
                            r_den   <= 1'b1;
                            r_state <= S_RD_REQ;
                        end
`endif
                    end else if (r_cnt == DRDY_LAST) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_DRDY;
                        r_busy     <= 1'b0;
                        r_pll_rst  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef PLL_DRP_READBACK_EN
                S_VF_WAIT: begin
                    if (if_cfg.drp_drdy && (if_cfg.drp_do != r_di)) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_VERIFY;
                        r_busy     <= 1'b0;
                        r_pll_rst  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (if_cfg.drp_drdy) begin
                        r_cnt <= '0;
                        if (w_last) begin
                            r_pll_rst <= 1'b0;
                            r_state   <= S_LOCK_WAIT;
                        end else begin
                            r_ptr   <= w_ptr_nxt;
                            r_daddr <= r_tbl_addr[w_ptr_nxt];
                            r_den   <= 1'b1;
                            r_state <= S_RD_REQ;
                        end
                    end else if (r_cnt == DRDY_LAST) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_DRDY;
                        r_busy     <= 1'b0;
                        r_pll_rst  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                S_LOCK_WAIT: begin
                    // The first two cycles after release are skipped so a stale pre-reset lock is not trusted.
                    if (w_lock_ok) begin
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_err_code <= '0;
                        r_state    <= S_FIN;
                    end else if (r_cnt == LOCK_LAST) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_LOCK;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_cfg.cfg_busy  = r_busy;
    assign if_cfg.cfg_done  = r_done;
    assign if_cfg.cfg_err   = r_err;
    assign if_cfg.err_code  = r_err_code;
    assign if_cfg.drp_daddr = r_daddr;
    assign if_cfg.drp_den   = r_den;
    assign if_cfg.drp_dwe   = r_dwe;
    assign if_cfg.drp_di    = r_di;
    assign if_cfg.pll_rst   = r_pll_rst;
endmodule

// File: tb/tb_pll_drp_cfg_ctrl.sv
// Directed bench for pll_drp_cfg_ctrl with a behavioural DRP slave and PLL lock model.
// Vector table drives multi-entry read-modify-write runs; hand sequences cover timeouts, guard and reset.
module tb_pll_drp_cfg_ctrl;
    localparam int DEPTH = 8;
`ifdef PLL_DRP_READBACK_EN
    localparam int ACC = 3;
`else
    localparam int ACC = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pll_drp_cfg_ctrl_if #(.DEPTH(DEPTH)) bus ();

    pll_drp_cfg_ctrl #(.DEPTH(DEPTH)) dut (
        .i_sysclk (clk),
        .i_sysrst (rst),
        .if_cfg   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Event monitor, sampled mid-cycle on the falling edge.
    int cyc = 0, done_total = 0, err_total = 0, den_total = 0;
    int rise_cyc = 0, fall_cyc = 0, first_den_cyc = 0, last_den_cyc = 0, done_cyc = 0, err_cyc = 0;
    bit prev_rst = 1'b0, den_seen = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.pll_rst && !prev_rst) begin
            rise_cyc = cyc;
            den_seen = 1'b0;
        end
        if (!bus.pll_rst && prev_rst) fall_cyc = cyc;
        prev_rst = bus.pll_rst;
        if (bus.drp_den) begin
            if (!den_seen) first_den_cyc = cyc;
            den_seen     = 1'b1;
            last_den_cyc = cyc;
            den_total++;
        end
        if (bus.cfg_done) begin
            done_total++;
            done_cyc = cyc;
        end
        if (bus.cfg_err) begin
            err_total++;
            err_cyc = cyc;
        end
    end

    // DRP slave: DRDY and DO appear lat cycles after DEN.
    int          lat = 3;
    bit          mute = 1'b0, corrupt = 1'b0;
    logic [15:0] init_mem [128];
    logic [15:0] wr_mem [128];
    bit          wr_vld [128];
    bit          pend = 1'b0;
    int          cd = 0;
    logic [15:0] rd_val = '0;
    logic [6:0]  wr_addr_q [$];
    logic [15:0] wr_di_q [$];

    always @(negedge clk) begin
        bus.drp_drdy = 1'b0;
        if (rst) begin
            pend = 1'b0;
            for (int i = 0; i < 128; i++) wr_vld[i] = 1'b0;
        end else begin
            if (pend) begin
                if (cd <= 1) begin
                    bus.drp_drdy = 1'b1;
                    bus.drp_do   = rd_val;
                    pend         = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (bus.drp_den) begin
                if (bus.drp_dwe) begin
                    wr_mem[bus.drp_daddr] = bus.drp_di;
                    wr_vld[bus.drp_daddr] = 1'b1;
                    wr_addr_q.push_back(bus.drp_daddr);
                    wr_di_q.push_back(bus.drp_di);
                end else begin
                    rd_val = wr_vld[bus.drp_daddr] ? wr_mem[bus.drp_daddr] : init_mem[bus.drp_daddr];
                    if (corrupt && wr_vld[bus.drp_daddr]) rd_val = rd_val ^ 16'h0001;
                end
                pend = !mute;
                cd   = lat;
            end
        end
    end

    // PLL model: locks lock_delay cycles after reset release; lock_delay < 0 never locks.
    int lock_delay = 50;
    bit lock_stuck = 1'b0;
    int lcnt = 0;
    always @(negedge clk) begin
        if (bus.pll_rst) begin
            lcnt           = 0;
            bus.pll_locked = lock_stuck;
        end else begin
            lcnt++;
            bus.pll_locked = lock_stuck || (lock_delay >= 0 && lcnt >= lock_delay);
        end
    end

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
        logic [15:0] init;
        logic [15:0] exp_di;
    } vec_t;
    vec_t vecs [4];

    int b_done, b_err, b_den, b_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic load(input int idx, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
        bus.ent_wr   = 1'b1;
        bus.ent_idx  = 3'(idx);
        bus.ent_addr = a;
        bus.ent_mask = m;
        bus.ent_data = d;
        step();
        bus.ent_wr = 1'b0;
    endtask

    task automatic snap();
        b_done = done_total;
        b_err  = err_total;
        b_den  = den_total;
        b_wr   = wr_addr_q.size();
    endtask

    task automatic start(input int num);
        bus.cfg_start = 1'b1;
        bus.ent_num   = 4'(num);
        step();
        bus.cfg_start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int n = 0;
        while (done_total == b_done && err_total == b_err && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no CFG_DONE/CFG_ERR within %0d cycles", name, budget);
        end
        repeat (3) step();
    endtask

    task automatic run(input string name, input int num, input int budget);
        snap();
        start(num);
        wait_end(name, budget);
    endtask

    function automatic logic [30:0] outs();
        return {bus.cfg_busy, bus.cfg_done, bus.cfg_err, bus.err_code, bus.drp_daddr,
                bus.drp_den, bus.drp_dwe, bus.drp_di, bus.pll_rst};
    endfunction

    initial begin
        bus.ent_wr = 1'b0; bus.ent_idx = '0; bus.ent_addr = '0; bus.ent_mask = '0;
        bus.ent_data = '0; bus.ent_num = '0; bus.cfg_start = 1'b0;
        bus.drp_do = '0; bus.drp_drdy = 1'b0; bus.pll_locked = 1'b0;
        for (int i = 0; i < 128; i++) init_mem[i] = 16'hFFFF;
        vecs[0] = '{addr: 7'h08, mask: 16'h1000, data: 16'h0145, init: 16'hFFFF, exp_di: 16'h1145};
        vecs[1] = '{addr: 7'h10, mask: 16'h00FF, data: 16'hAB00, init: 16'h1234, exp_di: 16'hAB34};
        vecs[2] = '{addr: 7'h7F, mask: 16'hFFFF, data: 16'h0000, init: 16'h5A5A, exp_di: 16'h5A5A};
        vecs[3] = '{addr: 7'h00, mask: 16'h0000, data: 16'hBEEF, init: 16'h0F0F, exp_di: 16'hBEEF};

        // Reset state
        do_reset();
        check("reset_outputs", 32'(outs()), 32'h0);

        // Single entry: DO=0xFFFF -> DI=0x1145, lock 50 cycles after release
        load(0, vecs[0].addr, vecs[0].mask, vecs[0].data);
        run("single", 1, 600);
        check("single_writes", 32'(wr_addr_q.size() - b_wr), 32'd1);
        check("single_addr", 32'(wr_addr_q[b_wr]), 32'h08);
        check("single_di", 32'(wr_di_q[b_wr]), 32'h1145);
        check("single_dens", 32'(den_total - b_den), 32'(ACC));
        check("single_hold_ge16", 32'(first_den_cyc - rise_cyc >= 16), 32'd1);
        check("single_done_pulses", 32'(done_total - b_done), 32'd1);
        check("single_lock_delay_ok", 32'(done_cyc - fall_cyc >= 50), 32'd1);
        check("single_end_state", 32'({bus.cfg_busy, bus.pll_rst, bus.err_code}), 32'h0);

        // Table-driven multi-entry read-modify-write
        do_reset();
        for (int i = 0; i < 4; i++) begin
            init_mem[vecs[i].addr] = vecs[i].init;
            load(i, vecs[i].addr, vecs[i].mask, vecs[i].data);
        end
        run("table", 4, 1000);
        check("table_writes", 32'(wr_addr_q.size() - b_wr), 32'd4);
        check("table_dens", 32'(den_total - b_den), 32'(4 * ACC));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("table_addr%0d", i), 32'(wr_addr_q[b_wr + i]), 32'(vecs[i].addr));
            check($sformatf("table_di%0d", i), 32'(wr_di_q[b_wr + i]), 32'(vecs[i].exp_di));
        end

        // ENT_NUM=12 clamps to DEPTH; entries 4..7 are still zero from reset
        run("clamp", 12, 2000);
        check("clamp_writes", 32'(wr_addr_q.size() - b_wr), 32'd8);
        check("clamp_dens", 32'(den_total - b_den), 32'(8 * ACC));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("clamp_w%0d", i), {9'h0, wr_addr_q[b_wr + i], wr_di_q[b_wr + i]},
                  (i < 4) ? {9'h0, vecs[i].addr, vecs[i].exp_di} : 32'h0);
        end

        // ENT_NUM=0: no DRP access, 16-cycle reset pulse
        run("zero", 0, 500);
        check("zero_dens", 32'(den_total - b_den), 32'd0);
        check("zero_rst_len", 32'(fall_cyc - rise_cyc), 32'd16);
        check("zero_done_pulses", 32'(done_total - b_done), 32'd1);

        // Lock stuck at 1: ignored for two guard cycles after release
        lock_stuck = 1'b1;
        run("stuck", 0, 500);
        check("stuck_done_offset", 32'(done_cyc - fall_cyc), 32'd3);
        lock_stuck = 1'b0;

        // DRDY never arrives
        mute = 1'b1;
        run("drdy_tmo", 1, 600);
        check("drdy_tmo_offset", 32'(err_cyc - last_den_cyc), 32'd255);
        check("drdy_tmo_code", 32'(bus.err_code), 32'd1);
        check("drdy_tmo_state", 32'({bus.cfg_busy, bus.pll_rst, bus.cfg_done}), 32'h0);
        check("drdy_tmo_err_pulses", 32'(err_total - b_err), 32'd1);
        mute = 1'b0;
        repeat (10) step();
        check("err_code_hold", 32'(bus.err_code), 32'd1);
        snap();
        start(0);
        check("err_code_clear", 32'(bus.err_code), 32'd0);
        wait_end("after_err", 500);

        // Start+write in the same IDLE cycle uses new entry; writes/starts while busy are ignored
        do_reset();
        snap();
        bus.ent_wr = 1'b1; bus.ent_idx = 3'd0; bus.ent_addr = vecs[0].addr;
        bus.ent_mask = vecs[0].mask; bus.ent_data = vecs[0].data;
        bus.cfg_start = 1'b1; bus.ent_num = 4'd1;
        step();
        bus.ent_wr = 1'b0; bus.cfg_start = 1'b0;
        repeat (3) step();
        bus.ent_wr = 1'b1; bus.ent_addr = 7'h22; bus.ent_mask = 16'h0000; bus.ent_data = 16'h0001;
        bus.cfg_start = 1'b1; bus.ent_num = 4'd2;
        step();
        bus.ent_wr = 1'b0; bus.cfg_start = 1'b0;
        wait_end("busy_ign", 600);
        check("same_cycle_entry", {9'h0, wr_addr_q[b_wr], wr_di_q[b_wr]}, {9'h0, 7'h08, 16'h1145});
        check("busy_num_kept", 32'(den_total - b_den), 32'(ACC));
        check("busy_start_ignored", 32'(done_total - b_done), 32'd1);
        run("busy_again", 1, 600);
        check("busy_table_kept", 32'(wr_addr_q[b_wr]), 32'h08);

        // Lock never arrives
        lock_delay = -1;
        run("lock_tmo", 0, 70000);
        check("lock_tmo_offset", 32'(err_cyc - fall_cyc), 32'd65535);
        check("lock_tmo_code", 32'(bus.err_code), 32'd2);
        check("lock_tmo_busy", 32'(bus.cfg_busy), 32'd0);
        lock_delay = 50;

        // Asynchronous reset while waiting in RD_WAIT
        lat = 20;
        snap();
        start(1);
        for (int n = 0; n < 100 && den_total == b_den; n++) step();
        step();
        step();
        check("pre_rst_busy", 32'({bus.cfg_busy, bus.pll_rst}), 32'h3);
        rst = 1'b1;
        #1;
        check("async_rst_outputs", 32'(outs()), 32'h0);
        step();
        rst = 1'b0;
        lat = 3;
        step();
        run("post_rst", 1, 600);
        check("post_rst_table_zero", {9'h0, wr_addr_q[b_wr], wr_di_q[b_wr]}, 32'h0);

`ifdef PLL_DRP_READBACK_EN
        // Readback corrupted in bit 0
        do_reset();
        corrupt = 1'b1;
        load(0, vecs[0].addr, vecs[0].mask, vecs[0].data);
        run("verify", 1, 600);
        check("verify_code", 32'(bus.err_code), 32'd3);
        check("verify_err_pulses", 32'(err_total - b_err), 32'd1);
        check("verify_dens", 32'(den_total - b_den), 32'd3);
        check("verify_rst_released", 32'(bus.pll_rst), 32'd0);
        corrupt = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
